// File: rtl/alu_issue_queue_pkg.sv
// Shared CPU types for the ALU issue queue.
// Payload bundle, register tags and the queue entry record.
package alu_issue_queue_pkg;

  typedef logic [5:0] reg_addr_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_ADDU,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic        rf_we;
    logic        use_imm;
    logic [15:0] imm;
  } decoded_inst_t;

  typedef struct packed {
    decoded_inst_t inst;
    reg_addr_t     phy_dest;
    logic [4:0]    rob_entry_num;
    reg_addr_t     src1;
    reg_addr_t     src2;
    logic [31:0]   src1_val;
    logic [31:0]   src2_val;
  } issue_to_execute_bus_t;

  typedef struct packed {
    issue_to_execute_bus_t payload;
    logic                  valid;
    logic                  rdy1;
    logic                  rdy2;
  } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_select.sv
// Lowest-index priority picker for the ALU issue queue.
// Emits a one-hot grant, its index and an any-grant flag.
module alu_iq_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 vld_o
);

  localparam int IW = $clog2(N);

  // Scanning downward lets the lowest requester win last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting ALU issue queue: oldest-first select, one issue per cycle.
// Define ALU_IQ_SPEC_WAKEUP_EN for speculative back-to-back wakeup.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WAKE_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  input  issue_to_execute_bus_t         dispatch_inst,
  input  logic [1:0]                    dispatch_src_ready,
  output logic                          iq_allowin,
  input  logic [WAKE_PORTS-1:0]         wakeup_valid,
  input  reg_addr_t [WAKE_PORTS-1:0]    wakeup_tag,
  output logic                          issue_to_alu_valid,
  output issue_to_execute_bus_t         issue_inst,
  output logic [$clog2(DEPTH):0]        iq_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int NT = WAKE_PORTS + 1;

  iq_entry_t [DEPTH-1:0]  ent_q, ent_d;
  iq_entry_t [DEPTH:0]    upd;
  iq_entry_t              new_ent;
  logic [IW:0]            cnt_q, cnt_d, wr_idx;
  logic                   iss_vld_q;
  issue_to_execute_bus_t  iss_q, iss_d;
  logic [DEPTH-1:0]       req, gnt;
  logic [IW-1:0]          gidx;
  logic                   gvld;
  logic                   disp_fire;
  logic                   spec_vld;
  reg_addr_t              spec_tag;
  logic [NT-1:0]          wk_vld;
  reg_addr_t [NT-1:0]     wk_tag;

  // Tag 0 is the hardwired zero register and never needs waking.
  function automatic logic woke(
    input reg_addr_t          t,
    input logic [NT-1:0]      v,
    input reg_addr_t [NT-1:0] tg
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NT; k++)
      hit = hit | (v[k] && (tg[k] == t) && (t != '0));
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      req[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
  end

  alu_iq_select #(.N(DEPTH)) u_sel (
    .req_i (req),
    .gnt_o (gnt),
    .idx_o (gidx),
    .vld_o (gvld)
  );

`ifdef ALU_IQ_SPEC_WAKEUP_EN
  assign spec_vld = gvld && ent_q[gidx].payload.inst.rf_we;
  assign spec_tag = ent_q[gidx].payload.phy_dest;
`else
  assign spec_vld = 1'b0;
  assign spec_tag = '0;
`endif

  assign wk_vld = {spec_vld, wakeup_valid};
  assign wk_tag = {spec_tag, wakeup_tag};

  assign iq_allowin = (cnt_q < (IW+1)'(DEPTH)) && !flush;
  assign disp_fire  = dispatch_valid && iq_allowin;
  assign wr_idx     = cnt_q - {{IW{1'b0}}, gvld};
  assign cnt_d      = cnt_q + {{IW{1'b0}}, disp_fire}
                            - {{IW{1'b0}}, gvld};
  assign iss_d      = gvld ? ent_q[gidx].payload : iss_q;

  always_comb begin
    new_ent         = '0;
    new_ent.payload = dispatch_inst;
    new_ent.valid   = 1'b1;
    new_ent.rdy1    = dispatch_src_ready[0]
                    | woke(dispatch_inst.src1, wk_vld, wk_tag);
    new_ent.rdy2    = dispatch_src_ready[1]
                    | woke(dispatch_inst.src2, wk_vld, wk_tag);
  end

  always_comb begin
    upd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      upd[i]      = ent_q[i];
      upd[i].rdy1 = ent_q[i].rdy1
                  | woke(ent_q[i].payload.src1, wk_vld, wk_tag);
      upd[i].rdy2 = ent_q[i].rdy2
                  | woke(ent_q[i].payload.src2, wk_vld, wk_tag);
    end
  end

  // Slots at or above the granted one pull from their upper neighbour.
  always_comb begin
    logic run;
    run   = 1'b0;
    ent_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      run      = run | gnt[i];
      ent_d[i] = run ? upd[i+1] : upd[i];
    end
    if (disp_fire)
      ent_d[wr_idx[IW-1:0]] = new_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q     <= '0;
      cnt_q     <= '0;
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
    end else if (flush) begin
      ent_q     <= '0;
      cnt_q     <= '0;
      iss_vld_q <= 1'b0;
    end else begin
      ent_q     <= ent_d;
      cnt_q     <= cnt_d;
      iss_vld_q <= gvld;
      iss_q     <= iss_d;
    end
  end

  assign issue_to_alu_valid = iss_vld_q;
  assign issue_inst         = iss_q;
  assign iq_count           = cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue.
// Expected values are hand-derived per step.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  dispatch_valid;
  issue_to_execute_bus_t dispatch_inst;
  logic [1:0]            dispatch_src_ready;
  logic                  iq_allowin;
  logic [1:0]            wakeup_valid;
  reg_addr_t [1:0]       wakeup_tag;
  logic                  issue_to_alu_valid;
  issue_to_execute_bus_t issue_inst;
  logic [3:0]            iq_count;

  int n_vec = 0;
  int n_bad = 0;

  alu_issue_queue dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_inst      (dispatch_inst),
    .dispatch_src_ready (dispatch_src_ready),
    .iq_allowin         (iq_allowin),
    .wakeup_valid       (wakeup_valid),
    .wakeup_tag         (wakeup_tag),
    .issue_to_alu_valid (issue_to_alu_valid),
    .issue_inst         (issue_inst),
    .iq_count           (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic issue_to_execute_bus_t mk(
    input alu_op_e op, input int d, input int s1, input int s2,
    input int rob
  );
    issue_to_execute_bus_t b;
    b               = '0;
    b.inst.op       = op;
    b.inst.rf_we    = 1'b1;
    b.phy_dest      = reg_addr_t'(d);
    b.src1          = reg_addr_t'(s1);
    b.src2          = reg_addr_t'(s2);
    b.rob_entry_num = 5'(rob);
    return b;
  endfunction

  task automatic disp(input issue_to_execute_bus_t b,
                      input logic [1:0] rdy);
    dispatch_valid     = 1'b1;
    dispatch_inst      = b;
    dispatch_src_ready = rdy;
  endtask

  task automatic wake(input int p, input int t);
    wakeup_valid[p] = 1'b1;
    wakeup_tag[p]   = reg_addr_t'(t);
  endtask

  task automatic idle();
    dispatch_valid     = 1'b0;
    dispatch_src_ready = 2'b00;
    wakeup_valid       = 2'b00;
    flush              = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    flush              = 1'b0;
    dispatch_valid     = 1'b0;
    dispatch_inst      = '0;
    dispatch_src_ready = 2'b00;
    wakeup_valid       = 2'b00;
    wakeup_tag         = '0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_count", iq_count, 0);
    chk("rst_issue", issue_to_alu_valid, 0);
    chk("rst_inst_zero", issue_inst === '0, 1);
    chk("rst_allowin", iq_allowin, 1);

    // Ready ADDU p5 <- p1, p2 into an empty queue
    disp(mk(ALU_ADDU, 5, 1, 2, 0), 2'b11);
    step();
    idle();
    chk("a_count1", iq_count, 1);
    chk("a_noissue", issue_to_alu_valid, 0);
    step();
    chk("a_issue", issue_to_alu_valid, 1);
    chk("a_dest", issue_inst.phy_dest, 5);
    chk("a_count0", iq_count, 0);
    step();
    chk("a_idle", issue_to_alu_valid, 0);

    // Fill with 8 waiting entries: dest 10+k, src1 20+k
    for (int k = 0; k < 8; k++) begin
      disp(mk(ALU_ADD, 10 + k, 20 + k, 0, k), 2'b10);
      step();
    end
    idle();
    chk("b_count8", iq_count, 8);
    chk("b_allowin0", iq_allowin, 0);
    disp(mk(ALU_ADD, 63, 1, 2, 9), 2'b11);
    step();
    idle();
    chk("b_full_hold", iq_count, 8);
    wake(0, 20);
    step();
    idle();
    chk("b_wait", issue_to_alu_valid, 0);
    step();
    chk("b_issue", issue_to_alu_valid, 1);
    chk("b_dest", issue_inst.phy_dest, 10);
    chk("b_count7", iq_count, 7);
    chk("b_allowin1", iq_allowin, 1);

    // Slots 0 and 3 become ready together
    wake(0, 21);
    wake(1, 24);
    step();
    idle();
    chk("c_wait", issue_to_alu_valid, 0);
    step();
    chk("c_first", issue_inst.phy_dest, 11);
    chk("c_count6", iq_count, 6);
    step();
    chk("c_second_v", issue_to_alu_valid, 1);
    chk("c_second", issue_inst.phy_dest, 14);
    chk("c_count5", iq_count, 5);
    step();
    chk("c_idle", issue_to_alu_valid, 0);

    // Flush with 5 entries, a ready head and a dispatch
    wake(0, 22);
    step();
    idle();
    flush = 1'b1;
    disp(mk(ALU_ADD, 40, 1, 2, 0), 2'b11);
    #1;
    chk("d_allowin_flush", iq_allowin, 0);
    step();
    idle();
    chk("d_count0", iq_count, 0);
    chk("d_noissue", issue_to_alu_valid, 0);
    step();
    chk("d_dropped", issue_to_alu_valid, 0);
    chk("d_still0", iq_count, 0);

    // Wakeup of tag 0 must not set a ready bit
    disp(mk(ALU_ADD, 30, 0, 0, 0), 2'b10);
    wake(0, 0);
    wake(1, 0);
    step();
    idle();
    step();
    chk("e_tag0_noissue", issue_to_alu_valid, 0);
    chk("e_count1", iq_count, 1);
    flush = 1'b1;
    step();
    idle();
    chk("e_flushed", iq_count, 0);

    // Same-cycle wakeup of p9 on dispatch
    disp(mk(ALU_ADD, 8, 9, 0, 0), 2'b10);
    wake(0, 9);
    step();
    idle();
    chk("f_count1", iq_count, 1);
    step();
    chk("f_issue", issue_to_alu_valid, 1);
    chk("f_dest", issue_inst.phy_dest, 8);
    chk("f_count0", iq_count, 0);

    // Dependent chain p6 <- p1 ; p7 <- p6
    disp(mk(ALU_ADD, 6, 1, 0, 0), 2'b11);
    step();
    disp(mk(ALU_ADD, 7, 6, 0, 0), 2'b10);
    step();
    idle();
    chk("g_prod_v", issue_to_alu_valid, 1);
    chk("g_prod", issue_inst.phy_dest, 6);
    chk("g_count1", iq_count, 1);
    step();
`ifdef ALU_IQ_SPEC_WAKEUP_EN
    chk("g_b2b_v", issue_to_alu_valid, 1);
    chk("g_b2b", issue_inst.phy_dest, 7);
    chk("g_b2b_count", iq_count, 0);
`else
    chk("g_gap", issue_to_alu_valid, 0);
    chk("g_gap_count", iq_count, 1);
    wake(0, 6);
    step();
    idle();
    chk("g_gap2", issue_to_alu_valid, 0);
    step();
    chk("g_dep_v", issue_to_alu_valid, 1);
    chk("g_dep", issue_inst.phy_dest, 7);
    chk("g_dep_count", iq_count, 0);
`endif

    // Reset mid-operation with a ready entry queued
    disp(mk(ALU_ADD, 12, 1, 2, 0), 2'b11);
    step();
    idle();
    reset = 1'b1;
    step();
    chk("h_rst_issue", issue_to_alu_valid, 0);
    chk("h_rst_count", iq_count, 0);
    chk("h_rst_inst", issue_inst === '0, 1);
    reset = 1'b0;
    step();
    chk("h_allowin", iq_allowin, 1);
    chk("h_idle", issue_to_alu_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, 4..16).
REQ-002 SHALL have parameter WAKE_PORTS, default 2, number of external wakeup ports.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discards all queued entries.
REQ-006 SHALL have port dispatch_valid  input  1  a dispatched ALU instruction is presented.
REQ-007 SHALL have port dispatch_inst  input  issue_to_execute_bus_t  payload: inst, phy_dest, rob_entry_num, src1/src2 tags.
REQ-008 SHALL have port dispatch_src_ready  input  2  per-source operand-ready bits from the busy table (1 when the source is unused).
REQ-009 SHALL have port iq_allowin  output  1  queue accepts dispatch this cycle.
REQ-010 SHALL have port wakeup_valid  input  WAKE_PORTS  tag broadcast valid.
REQ-011 SHALL have port wakeup_tag  input  WAKE_PORTS x reg_addr_t  physical register now available.
REQ-012 SHALL have port issue_to_alu_valid  output  1  an entry is issued this cycle.
REQ-013 SHALL have port issue_inst  output  issue_to_execute_bus_t  issued entry payload (src values filled downstream).
REQ-014 SHALL have port iq_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL store entries as a compacting queue: index 0 is oldest; on issue, all younger entries shift down one slot in the same cycle.
REQ-016 SHALL handshake dispatch: entry written when dispatch_valid && iq_allowin; iq_allowin = (iq_count < DEPTH) && !flush, from registered count only (no same-cycle issue credit).
REQ-017 SHALL write a new entry at slot iq_count, or iq_count-1 when an issue occurs the same cycle.
REQ-018 SHALL set each entry source ready bit when its tag matches any valid wakeup_tag; a matching wakeup in the dispatch cycle SHALL be ORed into dispatch_src_ready.
REQ-019 SHALL treat an entry as requesting when valid and both ready bits set; select the lowest-index requester.
REQ-020 SHALL register selection: issue_to_alu_valid/issue_inst reflect the selection made on the previous edge; minimum dispatch-to-issue latency 1 cycle when dispatched ready.
REQ-021 SHALL issue at most one entry per cycle; the issued entry is removed on the same edge it is registered to the output.
REQ-022 SHALL on flush clear every entry valid, iq_count and issue_to_alu_valid on the next edge; flush overrides simultaneous dispatch, wakeup and issue.
REQ-023 SHALL keep iq_count = valid entries; +1 dispatch, -1 issue, unchanged when both.
REQ-024 SHALL ignore wakeups for tag 0 (hardwired zero register, always ready).

Reset
REQ-025 SHALL on reset clear all entry valid and ready bits, iq_count=0, issue_to_alu_valid=0, issue_inst=0; iq_allowin=1 the cycle after reset deasserts.
REQ-026 SHALL treat reset asserted mid-operation identically to flush plus payload zeroing.

Configuration
REQ-027 SHALL support macro ALU_IQ_SPEC_WAKEUP_EN: when defined, the selected entry's phy_dest (if inst.rf_we) is broadcast internally as an extra wakeup tag in its select cycle, enabling back-to-back issue of dependent ALU ops; when undefined, only wakeup_tag ports set ready bits and a dependent op issues no earlier than one cycle after the external wakeup.

Structure
REQ-028 SHALL take issue_to_execute_bus_t, reg_addr_t and decoded_inst_t from the shared cpu package; an iq_entry_t typedef (payload + valid + two ready bits) SHALL be added there.
REQ-029 SHALL instantiate one sub-module alu_iq_select (lowest-index priority picker over DEPTH request bits, outputs one-hot grant and index).

Verification
REQ-030 Dispatch ready ADDU p5<-p1,p2 into empty queue -> issue_to_alu_valid=1 next cycle with phy_dest=5, iq_count back to 0.
REQ-031 Fill 8 non-ready entries -> iq_allowin=0 at count 8; wakeup of entry 0 tags -> entry 0 issues, iq_allowin=1 after.
REQ-032 Entries 0 and 3 both ready same cycle -> entry 0 issues first, entry 3 (now slot 2) next cycle.
REQ-033 Dispatch op with src1=p9 not ready while wakeup_tag[0]=9 same cycle -> entry issues next cycle.
REQ-034 With ALU_IQ_SPEC_WAKEUP_EN: chain ADD p6<-p1; ADD p7<-p6 -> issues in consecutive cycles; without it -> gap until external wakeup of p6.
REQ-035 Flush with 5 entries, simultaneous dispatch -> iq_count=0, no issue next cycle, dispatched instruction dropped.
